// File: rtl/vga_scanout.sv
// VGA scan-out: pixel-tick divider, h/v timing counters, integer upscaling of a
// small packed framebuffer, and a once-per-frame snapshot so the picture never tears.
module vga_scanout #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned HEIGHT     = 6,
  parameter int unsigned PIXEL_SIZE = 3,
  parameter int unsigned SCALE      = 80,
  parameter int unsigned H_VISIBLE  = 640,
  parameter int unsigned H_FRONT    = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BACK     = 48,
  parameter int unsigned V_VISIBLE  = 480,
  parameter int unsigned V_FRONT    = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BACK     = 33,
  parameter int unsigned CLK_DIV    = 2
) (
  input  logic                                 clk,
  input  logic                                 resetn,
  input  logic [WIDTH*HEIGHT*PIXEL_SIZE-1:0]   packed_buffer,
  output logic                                 hsync_n,
  output logic                                 vsync_n,
  output logic [PIXEL_SIZE-1:0]                pixel,
  output logic                                 video_on,
  output logic                                 vblank_start
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned FB_W    = WIDTH * HEIGHT * PIXEL_SIZE;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned HC_W    = $clog2(H_TOTAL);
  localparam int unsigned VC_W    = $clog2(V_TOTAL);
  localparam int unsigned COL_W   = $clog2(WIDTH + 1);
  localparam int unsigned ROW_W   = $clog2(HEIGHT + 1);
  localparam int unsigned SUB_W   = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int unsigned IDX_W   = $clog2(WIDTH * HEIGHT + 1);
  localparam int unsigned BIT_W   = $clog2(FB_W + 1);

  logic [DIV_W-1:0]      div_q, div_d;
  logic [HC_W-1:0]       h_q, h_d;
  logic [VC_W-1:0]       v_q, v_d;
  logic [COL_W-1:0]      col_q, col_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic [SUB_W-1:0]      sx_q, sx_d;
  logic [SUB_W-1:0]      sy_q, sy_d;
  logic [FB_W-1:0]       frame_q, frame_d;
  logic                  hsync_q, hsync_d;
  logic                  vsync_q, vsync_d;
  logic [PIXEL_SIZE-1:0] pixel_q, pixel_d;
  logic                  video_q, video_d;
  logic                  vblank_q, vblank_d;

  logic                  pix_en_c;
  logic                  h_last_c, v_last_c, h_vis_c, v_vis_c, vis_c;
  logic [IDX_W-1:0]      pix_idx_c;
  logic [BIT_W-1:0]      bit_base_c;
  logic [PIXEL_SIZE-1:0] fb_pix_c;

  assign pix_en_c = (div_q == DIV_W'(CLK_DIV - 1));
  assign h_last_c = (h_q == HC_W'(H_TOTAL - 1));
  assign v_last_c = (v_q == VC_W'(V_TOTAL - 1));
  assign h_vis_c  = (h_q < HC_W'(H_VISIBLE));
  assign v_vis_c  = (v_q < VC_W'(V_VISIBLE));
  assign vis_c    = h_vis_c && v_vis_c;

  // Pixel lookup; base forced to 0 outside the visible area where row/col may overrun.
  assign pix_idx_c  = IDX_W'(row_q) * IDX_W'(WIDTH) + IDX_W'(col_q);
  assign bit_base_c = vis_c ? BIT_W'(pix_idx_c) * BIT_W'(PIXEL_SIZE) : '0;
  assign fb_pix_c   = frame_q[bit_base_c +: PIXEL_SIZE];

  always_comb begin
    div_d    = pix_en_c ? '0 : DIV_W'(div_q + 1'b1);
    h_d      = h_q;
    v_d      = v_q;
    col_d    = col_q;
    row_d    = row_q;
    sx_d     = sx_q;
    sy_d     = sy_q;
    frame_d  = frame_q;
    hsync_d  = hsync_q;
    vsync_d  = vsync_q;
    pixel_d  = pixel_q;
    video_d  = video_q;
    vblank_d = 1'b0;

    if (pix_en_c) begin
      // Outputs reflect the counters as sampled on this tick.
      video_d  = vis_c;
      pixel_d  = vis_c ? fb_pix_c : '0;
      hsync_d  = !((h_q >= HC_W'(H_VISIBLE + H_FRONT)) &&
                   (h_q <  HC_W'(H_VISIBLE + H_FRONT + H_SYNC)));
      vsync_d  = !((v_q >= VC_W'(V_VISIBLE + V_FRONT)) &&
                   (v_q <  VC_W'(V_VISIBLE + V_FRONT + V_SYNC)));
      vblank_d = (h_q == '0) && (v_q == VC_W'(V_VISIBLE));

      if (h_last_c) begin
        h_d   = '0;
        col_d = '0;
        sx_d  = '0;
        if (v_last_c) begin
          v_d     = '0;
          row_d   = '0;
          sy_d    = '0;
          frame_d = packed_buffer;
        end else begin
          v_d = VC_W'(v_q + 1'b1);
          if (v_vis_c) begin
            if (sy_q == SUB_W'(SCALE - 1)) begin
              sy_d  = '0;
              row_d = ROW_W'(row_q + 1'b1);
            end else begin
              sy_d = SUB_W'(sy_q + 1'b1);
            end
          end
        end
      end else begin
        h_d = HC_W'(h_q + 1'b1);
        if (h_vis_c) begin
          if (sx_q == SUB_W'(SCALE - 1)) begin
            sx_d  = '0;
            col_d = COL_W'(col_q + 1'b1);
          end else begin
            sx_d = SUB_W'(sx_q + 1'b1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_q    <= '0;
      h_q      <= '0;
      v_q      <= '0;
      col_q    <= '0;
      row_q    <= '0;
      sx_q     <= '0;
      sy_q     <= '0;
      frame_q  <= '0;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      pixel_q  <= '0;
      video_q  <= 1'b0;
      vblank_q <= 1'b0;
    end else begin
      div_q    <= div_d;
      h_q      <= h_d;
      v_q      <= v_d;
      col_q    <= col_d;
      row_q    <= row_d;
      sx_q     <= sx_d;
      sy_q     <= sy_d;
      frame_q  <= frame_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      pixel_q  <= pixel_d;
      video_q  <= video_d;
      vblank_q <= vblank_d;
    end
  end

  assign hsync_n      = hsync_q;
  assign vsync_n      = vsync_q;
  assign pixel        = pixel_q;
  assign video_on     = video_q;
  assign vblank_start = vblank_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: two instances (pixel tick every clk and every 3rd clk)
// checked each clk against an arithmetic model, plus a vector table and corner sequences.
module tb_vga_scanout;

  localparam int unsigned W = 4, H = 2, P = 3, S = 2;
  localparam int unsigned HV = 8, HF = 2, HS = 2, HB = 2;
  localparam int unsigned VV = 4, VF = 1, VS = 1, VB = 1;
  localparam int unsigned HT = HV + HF + HS + HB;
  localparam int unsigned VT = VV + VF + VS + VB;
  localparam int unsigned FT = HT * VT;
  localparam int unsigned PBW = W * H * P;

  typedef struct packed {
    logic [P-1:0] pix;
    logic         von;
    logic         hs;
    logic         vs;
    logic         vb;
  } out_t;

  typedef struct {
    int frame; int line; int h;
    int pix; int von; int hs; int vs; int vb;
  } vec_t;

  localparam out_t RST_OUT = '{pix: '0, von: 1'b0, hs: 1'b1, vs: 1'b1, vb: 1'b0};

  logic clk = 1'b0;
  logic resetn;
  logic [PBW-1:0] pb;
  logic hs1, vs1, von1, vb1, hs3, vs3, von3, vb3;
  logic [P-1:0] pix1, pix3;

  always #5 clk = ~clk;

  vga_scanout #(.WIDTH(W), .HEIGHT(H), .PIXEL_SIZE(P), .SCALE(S),
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .CLK_DIV(1)) dut1 (
    .clk(clk), .resetn(resetn), .packed_buffer(pb), .hsync_n(hs1), .vsync_n(vs1),
    .pixel(pix1), .video_on(von1), .vblank_start(vb1));

  vga_scanout #(.WIDTH(W), .HEIGHT(H), .PIXEL_SIZE(P), .SCALE(S),
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .CLK_DIV(3)) dut3 (
    .clk(clk), .resetn(resetn), .packed_buffer(pb), .hsync_n(hs3), .vsync_n(vs3),
    .pixel(pix3), .video_on(von3), .vblank_start(vb3));

  // Expected outputs for pixel tick number t since reset, given the displayed snapshot.
  function automatic out_t tick_out(input int t, input logic [PBW-1:0] snap);
    out_t o;
    int hh, vv, idx;
    hh = t % HT;
    vv = (t / HT) % VT;
    o.von = (hh < HV) && (vv < VV);
    o.pix = '0;
    if (o.von) begin
      idx = ((vv / S) * W + hh / S) * P;
      o.pix = snap[idx +: P];
    end
    o.hs = !((hh >= HV + HF) && (hh < HV + HF + HS));
    o.vs = !((vv >= VV + VF) && (vv < VV + VF + VS));
    o.vb = (hh == 0) && (vv == VV);
    return o;
  endfunction

  int c1, c3;
  logic [PBW-1:0] snap1, snap3;
  out_t e1, e3;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      c1 <= 0; snap1 <= '0; e1 <= RST_OUT;
    end else begin
      e1 <= tick_out(c1, snap1);
      if (c1 % FT == FT - 1) snap1 <= pb;
      c1 <= c1 + 1;
    end
  end

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      c3 <= 0; snap3 <= '0; e3 <= RST_OUT;
    end else begin
      if (c3 % 3 == 2) begin
        e3 <= tick_out(c3 / 3, snap3);
        if ((c3 / 3) % FT == FT - 1) snap3 <= pb;
      end else begin
        e3.vb <= 1'b0;
      end
      c3 <= c3 + 1;
    end
  end

  int checks = 0;
  int errors = 0;
  int phase = 0;
  logic [PBW-1:0] pat;
  logic [P+2:0] prev3;
  logic vb3_prev;
  int vb1_pos[$];
  int vb3_pos[$];
  vec_t tv[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d, time %0t)", name, act, exp, c1, $time);
    end
  endtask

  task automatic compare_all();
    chk("d1 pixel",    int'(pix1), int'(e1.pix));
    chk("d1 video_on", int'(von1), int'(e1.von));
    chk("d1 hsync_n",  int'(hs1),  int'(e1.hs));
    chk("d1 vsync_n",  int'(vs1),  int'(e1.vs));
    chk("d1 vblank",   int'(vb1),  int'(e1.vb));
    chk("d3 pixel",    int'(pix3), int'(e3.pix));
    chk("d3 video_on", int'(von3), int'(e3.von));
    chk("d3 hsync_n",  int'(hs3),  int'(e3.hs));
    chk("d3 vsync_n",  int'(vs3),  int'(e3.vs));
    chk("d3 vblank",   int'(vb3),  int'(e3.vb));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " d1 hsync_n"}, int'(hs1), 1);
    chk({tag, " d1 vsync_n"}, int'(vs1), 1);
    chk({tag, " d1 pixel"},   int'(pix1), 0);
    chk({tag, " d1 video_on"}, int'(von1), 0);
    chk({tag, " d1 vblank"},  int'(vb1), 0);
    chk({tag, " d3 hsync_n"}, int'(hs3), 1);
    chk({tag, " d3 vsync_n"}, int'(vs3), 1);
    chk({tag, " d3 pixel"},   int'(pix3), 0);
    chk({tag, " d3 video_on"}, int'(von3), 0);
    chk({tag, " d3 vblank"},  int'(vb3), 0);
  endtask

  // One clk: compare everything, run the side monitors, then apply scheduled stimulus.
  task automatic step();
    @(negedge clk);
    compare_all();
    if (vb1 && c1 <= 3 * int'(FT)) vb1_pos.push_back(c1);
    if (vb3) begin
      chk("d3 vblank single clk", int'(vb3_prev), 0);
      vb3_pos.push_back(c3);
    end
    vb3_prev = vb3;
    if (resetn && (c3 % 3 != 0)) chk("d3 holds between ticks", int'({pix3, von3, hs3, vs3}), int'(prev3));
    prev3 = {pix3, von3, hs3, vs3};
    if (phase == 1) begin
      if (c1 == 128) pb = pat;
      if (c1 == 216) pb = '1;
    end else if (phase == 2) begin
      if ($urandom_range(0, 39) == 0) pb = PBW'($urandom);
    end
  endtask

  task automatic add(input int f, input int l, input int hh, input int p,
                     input int vo, input int hsn, input int vsn, input int vbs);
    tv.push_back(vec_t'{f, l, hh, p, vo, hsn, vsn, vbs});
  endtask

  initial begin
    int t, guard, target;
    int nz;
    pat = '0;
    for (int r = 0; r < int'(H); r++)
      for (int c = 0; c < int'(W); c++)
        pat[(r * W + c) * P +: P] = P'((r * 4 + c) % 8);

    // frame 0 (black, timing), frame 1 (all ones), frame 2 (pattern), frame 3 (all 7)
    add(0,0,0, 0,1,1,1,0); add(0,0,7, 0,1,1,1,0); add(0,0,8, 0,0,1,1,0);
    add(0,0,9, 0,0,1,1,0); add(0,0,10,0,0,0,1,0); add(0,0,11,0,0,0,1,0);
    add(0,0,12,0,0,1,1,0); add(0,3,7, 0,1,1,1,0); add(0,4,0, 0,0,1,1,1);
    add(0,4,1, 0,0,1,1,0); add(0,5,0, 0,0,1,0,0); add(0,5,13,0,0,1,0,0);
    add(0,6,0, 0,0,1,1,0);
    add(1,0,3, 7,1,1,1,0); add(1,1,8, 0,0,1,1,0); add(1,3,7, 7,1,1,1,0);
    add(2,0,0,0,1,1,1,0); add(2,0,1,0,1,1,1,0); add(2,0,2,1,1,1,1,0); add(2,0,3,1,1,1,1,0);
    add(2,0,4,2,1,1,1,0); add(2,0,5,2,1,1,1,0); add(2,0,6,3,1,1,1,0); add(2,0,7,3,1,1,1,0);
    add(2,1,2,1,1,1,1,0);
    add(2,2,0,4,1,1,1,0); add(2,2,1,4,1,1,1,0); add(2,2,2,5,1,1,1,0); add(2,2,3,5,1,1,1,0);
    add(2,2,4,6,1,1,1,0); add(2,2,5,6,1,1,1,0); add(2,2,6,7,1,1,1,0); add(2,2,7,7,1,1,1,0);
    add(2,3,0,4,1,1,1,0); add(2,5,3,0,0,1,0,0);
    add(3,0,0,7,1,1,1,0); add(3,2,1,7,1,1,1,0);

    pb = '1;
    resetn = 1'b1;
    vb3_prev = 1'b0;
    prev3 = '0;
    #3 resetn = 1'b0;
    step();
    step();
    chk_reset_outputs("reset");
    resetn = 1'b1;
    phase = 1;

    foreach (tv[i]) begin
      t = tv[i].frame * int'(FT) + tv[i].line * int'(HT) + tv[i].h;
      guard = 0;
      while (c1 < t + 1 && guard < 5000) begin step(); guard++; end
      chk($sformatf("tv%0d sample point", i), c1, t + 1);
      chk($sformatf("tv%0d pixel", i),    int'(pix1), tv[i].pix);
      chk($sformatf("tv%0d video_on", i), int'(von1), tv[i].von);
      chk($sformatf("tv%0d hsync_n", i),  int'(hs1),  tv[i].hs);
      chk($sformatf("tv%0d vsync_n", i),  int'(vs1),  tv[i].vs);
      chk($sformatf("tv%0d vblank", i),   int'(vb1),  tv[i].vb);
    end

    phase = 2;
    while (c1 < 1200) step();

    chk("d1 vblank count over 3 frames", vb1_pos.size(), 3);
    foreach (vb1_pos[i]) chk($sformatf("d1 vblank pos %0d", i), vb1_pos[i], 57 + 98 * i);
    chk("d3 vblank count", vb3_pos.size(), 4);
    if (vb3_pos.size() > 0) chk("d3 first vblank", vb3_pos[0], 171);
    for (int i = 1; i < vb3_pos.size(); i++)
      chk($sformatf("d3 frame period %0d", i), vb3_pos[i] - vb3_pos[i-1], 294);

    // Mid-frame reset at line 2, h=5 of the next frame.
    phase = 0;
    target = (c1 / int'(FT) + 1) * int'(FT) + 2 * int'(HT) + 5 + 1;
    guard = 0;
    while (c1 < target && guard < 500) begin step(); guard++; end
    chk("pre-reset video_on", int'(von1), 1);
    resetn = 1'b0;
    #1;
    chk_reset_outputs("mid-frame reset");
    step();
    step();
    pb = '1;
    resetn = 1'b1;
    nz = 0;
    step();
    chk("restart video_on at (0,0)", int'(von1), 1);
    chk("restart hsync_n at (0,0)", int'(hs1), 1);
    for (int i = 0; i < int'(FT); i++) begin
      if (pix1 != '0) nz++;
      step();
    end
    chk("black first frame after reset", nz, 0);
    while (c1 < int'(FT) + 1 + 3) step();
    chk("second frame after reset shows buffer", int'(pix1), 7);
    while (c1 < 2 * int'(FT) + 10) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
